// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: opcodes, functs, ALU ops, FSM states.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Ports: none. Imported by mc_ctrl_if, mc_alu_dec and mc_ctrl.
package mc_ctrl_pkg;

    typedef logic [5:0] op_t;
    typedef logic [5:0] funct_t;
    typedef logic [4:0] aluop_t;

    // Instruction opcodes
    localparam op_t OP_RTYPE = 6'b000000;
    localparam op_t OP_J     = 6'b000010;
    localparam op_t OP_BEQ   = 6'b000100;
    localparam op_t OP_ADDIU = 6'b001001;
    localparam op_t OP_ORI   = 6'b001101;
    localparam op_t OP_LW    = 6'b100011;
    localparam op_t OP_SW    = 6'b101011;

    // R-type function codes
    localparam funct_t F_ADD  = 6'b100000;
    localparam funct_t F_ADDU = 6'b100001;
    localparam funct_t F_SUBU = 6'b100011;
    localparam funct_t F_AND  = 6'b100100;
    localparam funct_t F_OR   = 6'b100101;
    localparam funct_t F_SLT  = 6'b101010;

    // ALU operations
    localparam aluop_t ALU_ADD  = 5'b00000;
    localparam aluop_t ALU_ADDU = 5'b00001;
    localparam aluop_t ALU_SUBU = 5'b00010;
    localparam aluop_t ALU_AND  = 5'b00011;
    localparam aluop_t ALU_OR   = 5'b00100;
    localparam aluop_t ALU_SLT  = 5'b00101;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_EXEC_I   = 4'd3,
        ST_MEM_ADDR = 4'd4,
        ST_MEM_RD   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_WB_R     = 4'd7,
        ST_WB_I     = 4'd8,
        ST_WB_MEM   = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11,
        ST_TRAP     = 4'd12
    } state_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields/flags in, control strobes out.
// Latency: n/a (wires only).
// Backpressure: mem_ready stalls the controller in FETCH, MEM_RD and MEM_WR.
// Modports: master = controller (drives strobes), slave = datapath (drives op/funct/zero/mem_ready).
interface mc_ctrl_if;
    import mc_ctrl_pkg::*;

    op_t      op;
    funct_t   funct;
    logic     zero;
    logic     mem_ready;

    aluop_t   aluop;
    logic     alu_src_a;
    logic [1:0] alu_src_b;
    logic     pc_we;
    logic     ir_we;
    logic     mem_re;
    logic     mem_we;
    logic     rf_we;
    logic [1:0] pc_src;
    logic     reg_dst;
    logic     mem_to_reg;
    logic     iord;
    logic     illegal;

    modport master (
        input  op, funct, zero, mem_ready,
        output aluop, alu_src_a, alu_src_b, pc_we, ir_we, mem_re, mem_we,
               rf_we, pc_src, reg_dst, mem_to_reg, iord, illegal
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  aluop, alu_src_a, alu_src_b, pc_we, ir_we, mem_re, mem_we,
               rf_we, pc_src, reg_dst, mem_to_reg, iord, illegal
    );
endinterface

// File: rtl/mc_alu_dec.sv
// ALU operation decode from R-type funct and I-type opcode.
// Latency: combinational.
// Backpressure: none.
// Ports: op, funct in; funct_aluop/funct_ok (R-type) and imm_aluop (I-type) out.
module mc_alu_dec
    import mc_ctrl_pkg::*;
(
    input  op_t    op,
    input  funct_t funct,
    output aluop_t funct_aluop,
    output logic   funct_ok,
    output aluop_t imm_aluop
);

    always_comb begin
        funct_aluop = ALU_ADDU;
        funct_ok    = 1'b1;
        case (funct)
            F_ADD:   funct_aluop = ALU_ADD;
            F_ADDU:  funct_aluop = ALU_ADDU;
            F_SUBU:  funct_aluop = ALU_SUBU;
            F_AND:   funct_aluop = ALU_AND;
            F_OR:    funct_aluop = ALU_OR;
            F_SLT:   funct_aluop = ALU_SLT;
            default: funct_ok    = 1'b0;
        endcase
    end

    // Only addiu and ori reach EXEC_I, so anything but ori is an add.
    assign imm_aluop = (op == OP_ORI) ? ALU_OR : ALU_ADDU;

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle CPU control FSM (Moore decodes, Mealy pc_we/ir_we in FETCH and pc_we in BRANCH).
// Latency: R/I 4, lw 5, sw 4, beq 3, j 3 cycles; +1 per mem_ready-low cycle.
// Backpressure: holds in FETCH/MEM_RD/MEM_WR until mem_ready.
// Ports: clk, rst_n (async active-low), bus (mc_ctrl_if.master).
// Option: ILLEGAL_TRAP_EN -> unknown instructions park in TRAP with sticky illegal;
//         otherwise they retire as a NOP and illegal is constant 0.
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    mc_ctrl_if.master bus
);

`ifdef ILLEGAL_TRAP_EN
    localparam state_t UNKNOWN_NEXT = ST_TRAP;
`else
    localparam state_t UNKNOWN_NEXT = ST_FETCH;
`endif

    state_t state_q, state_d;
    // run_q is low during reset and for the partial cycle after release, so the
    // first FETCH cycle starts at the first rising edge after rst_n goes high.
    logic   run_q, run_d;
    logic   illegal_q, illegal_d;

    aluop_t funct_aluop;
    aluop_t imm_aluop;
    logic   funct_ok;

    mc_alu_dec u_alu_dec (
        .op          (bus.op),
        .funct       (bus.funct),
        .funct_aluop (funct_aluop),
        .funct_ok    (funct_ok),
        .imm_aluop   (imm_aluop)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            run_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d = state_q;
        run_d   = 1'b1;
        if (run_q) begin
            case (state_q)
                ST_FETCH:    if (bus.mem_ready) state_d = ST_DECODE;
                ST_DECODE: begin
                    case (bus.op)
                        OP_RTYPE:         state_d = ST_EXEC_R;
                        OP_LW, OP_SW:     state_d = ST_MEM_ADDR;
                        OP_BEQ:           state_d = ST_BRANCH;
                        OP_J:             state_d = ST_JUMP;
                        OP_ADDIU, OP_ORI: state_d = ST_EXEC_I;
                        default:          state_d = UNKNOWN_NEXT;
                    endcase
                end
                ST_EXEC_R:   state_d = funct_ok ? ST_WB_R : UNKNOWN_NEXT;
                ST_EXEC_I:   state_d = ST_WB_I;
                ST_MEM_ADDR: state_d = (bus.op == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
                ST_MEM_RD:   if (bus.mem_ready) state_d = ST_WB_MEM;
                ST_MEM_WR:   if (bus.mem_ready) state_d = ST_FETCH;
                ST_TRAP:     state_d = ST_TRAP;
                default:     state_d = ST_FETCH;
            endcase
        end
`ifdef ILLEGAL_TRAP_EN
        illegal_d = illegal_q | (state_d == ST_TRAP);
`else
        illegal_d = 1'b0;
`endif
    end

    always_comb begin
        bus.aluop      = ALU_ADDU;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'd0;
        bus.pc_we      = 1'b0;
        bus.ir_we      = 1'b0;
        bus.mem_re     = 1'b0;
        bus.mem_we     = 1'b0;
        bus.rf_we      = 1'b0;
        bus.pc_src     = 2'd0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.iord       = 1'b0;
        if (!run_q) begin
            bus.aluop = ALU_ADD;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    bus.mem_re    = 1'b1;
                    bus.alu_src_b = 2'd1;
                    bus.pc_we     = bus.mem_ready;
                    bus.ir_we     = bus.mem_ready;
                end
                ST_DECODE:   bus.alu_src_b = 2'd3;
                ST_EXEC_R: begin
                    bus.alu_src_a = 1'b1;
                    bus.aluop     = funct_aluop;
                end
                ST_EXEC_I: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'd2;
                    bus.aluop     = imm_aluop;
                end
                ST_MEM_ADDR: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'd2;
                end
                ST_MEM_RD: begin
                    bus.mem_re = 1'b1;
                    bus.iord   = 1'b1;
                end
                ST_MEM_WR: begin
                    bus.mem_we = 1'b1;
                    bus.iord   = 1'b1;
                end
                ST_WB_R: begin
                    bus.rf_we   = 1'b1;
                    bus.reg_dst = 1'b1;
                end
                ST_WB_I:     bus.rf_we = 1'b1;
                ST_WB_MEM: begin
                    bus.rf_we      = 1'b1;
                    bus.mem_to_reg = 1'b1;
                end
                ST_BRANCH: begin
                    bus.alu_src_a = 1'b1;
                    bus.aluop     = ALU_SUBU;
                    bus.pc_src    = 2'd1;
                    bus.pc_we     = bus.zero;
                end
                ST_JUMP: begin
                    bus.pc_src = 2'd2;
                    bus.pc_we  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-cycle control vector vs. a step-list reference model.
// Latency: n/a.
// Backpressure: mem_ready low cycles are injected at every memory step.
module tb_mc_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mc_ctrl_if bus();

    mc_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // {aluop, src_a, src_b, pc_we, ir_we, mem_re, mem_we, rf_we, pc_src, reg_dst, mem_to_reg, iord, illegal}
    logic [18:0] dut_v;
    assign dut_v = {bus.aluop, bus.alu_src_a, bus.alu_src_b, bus.pc_we, bus.ir_we,
                    bus.mem_re, bus.mem_we, bus.rf_we, bus.pc_src, bus.reg_dst,
                    bus.mem_to_reg, bus.iord, bus.illegal};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic known_funct(input logic [5:0] f);
        return f inside {6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101010};
    endfunction

    function automatic logic known_op(input logic [5:0] o);
        return o inside {6'b000000, 6'b000010, 6'b000100, 6'b001001, 6'b001101, 6'b100011, 6'b101011};
    endfunction

    function automatic logic [4:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 5'b00000;
            6'b100001: return 5'b00001;
            6'b100011: return 5'b00010;
            6'b100100: return 5'b00011;
            6'b100101: return 5'b00100;
            6'b101010: return 5'b00101;
            default:   return 5'b00001;
        endcase
    endfunction

    // Expected control vector for one step of an instruction.
    // F fetch, D decode, X exec-R, I exec-I, R wb-R, J wb-I, M mem-addr,
    // L mem-read, W wb-mem, S mem-write, B branch, P jump, T trap.
    function automatic logic [18:0] exp_out(input byte c, input logic mr, input logic z,
                                            input logic [5:0] o, input logic [5:0] f);
        logic [4:0] alu = 5'b00001;
        logic       a = 0, pw = 0, iw = 0, re = 0, we = 0, rw = 0, rd = 0, m2r = 0, io = 0, il = 0;
        logic [1:0] b = 0, ps = 0;
        case (c)
            "F": begin re = 1; b = 2'd1; pw = mr; iw = mr; end
            "D": b = 2'd3;
            "X": begin a = 1; alu = funct_alu(f); end
            "I": begin a = 1; b = 2'd2; alu = (o == 6'b001101) ? 5'b00100 : 5'b00001; end
            "R": begin rw = 1; rd = 1; end
            "J": rw = 1;
            "M": begin a = 1; b = 2'd2; end
            "L": begin re = 1; io = 1; end
            "W": begin rw = 1; m2r = 1; end
            "S": begin we = 1; io = 1; end
            "B": begin a = 1; alu = 5'b00010; ps = 2'd1; pw = z; end
            "P": begin ps = 2'd2; pw = 1; end
            "T": il = 1;
            default: ;
        endcase
        return {alu, a, b, pw, iw, re, we, rw, ps, rd, m2r, io, il};
    endfunction

    // Entry and exit: just after a rising edge. Memory steps see nw low cycles first.
    task automatic run_steps(input string s, input logic [5:0] o, input logic [5:0] f,
                             input logic z, input int nw, input int abort_at);
        bus.op    = o;
        bus.funct = f;
        bus.zero  = z;
        for (int i = 0; i < s.len(); i++) begin
            byte c;
            int  w;
            c = s[i];
            w = (c == "F" || c == "L" || c == "S") ? nw : 0;
            for (int k = 0; k <= w; k++) begin
                bus.mem_ready = (k == w);
                @(negedge clk);
                chk($sformatf("step_%c_op%b_k%0d", c, o, k), dut_v,
                    exp_out(c, bus.mem_ready, z, o, f));
                if (abort_at == i) return;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1 chk("reset_async", dut_v, 19'd0);
        @(posedge clk);
        @(negedge clk);
        chk("reset_held", dut_v, 19'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input int nw, input int abort_at);
        string s;
        logic  bad;
        bad = 1'b0;
        case (o)
            6'b000000: begin
                if (known_funct(f)) s = "FDXR";
                else begin s = "FDX"; bad = 1'b1; end
            end
            6'b001001, 6'b001101: s = "FDIJ";
            6'b100011: s = "FDMLW";
            6'b101011: s = "FDMS";
            6'b000100: s = "FDB";
            6'b000010: s = "FDP";
            default: begin s = "FD"; bad = 1'b1; end
        endcase
        run_steps(s, o, f, z, nw, abort_at);
        if (abort_at >= 0) begin
            do_reset();
        end else if (bad) begin
`ifdef ILLEGAL_TRAP_EN
            run_steps("TTT", o, f, z, 0, -1);
            do_reset();
`endif
        end
    endtask

    initial begin
        logic [5:0] o, f;
        bus.op = 6'd0;
        bus.funct = 6'd0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        do_reset();

        run_instr(6'b000000, 6'b101010, 1'b0, 0, -1);  // slt
        run_instr(6'b100011, 6'b000000, 1'b0, 0, -1);  // lw, no waits
        run_instr(6'b100011, 6'b000000, 1'b0, 2, 3);   // reset in MEM_RD while waiting
        run_instr(6'b101011, 6'b000000, 1'b0, 3, -1);  // sw with 3 wait cycles
        run_instr(6'b000100, 6'b000000, 1'b1, 0, -1);  // beq taken
        run_instr(6'b000100, 6'b000000, 1'b0, 0, -1);  // beq not taken
        run_instr(6'b111111, 6'b000000, 1'b0, 0, -1);  // unknown op
        run_instr(6'b000000, 6'b111000, 1'b0, 0, -1);  // unknown funct
        run_instr(6'b000010, 6'b000000, 1'b0, 1, -1);  // j
        run_instr(6'b001001, 6'b000000, 1'b0, 0, -1);  // addiu
        run_instr(6'b001101, 6'b000000, 1'b0, 1, -1);  // ori

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0, 1: begin
                    o = 6'b000000;
                    case ($urandom_range(0, 6))
                        0: f = 6'b100000;
                        1: f = 6'b100001;
                        2: f = 6'b100011;
                        3: f = 6'b100100;
                        4: f = 6'b100101;
                        5: f = 6'b101010;
                        default: f = 6'($urandom_range(0, 63));
                    endcase
                end
                2: o = 6'b001001;
                3: o = 6'b001101;
                4: o = 6'b100011;
                5: o = 6'b101011;
                6: o = 6'b000100;
                7: o = 6'b000010;
                8: begin
                    o = 6'($urandom_range(0, 63));
                    if (known_op(o)) o = 6'b111110;
                end
                default: o = 6'b000000;
            endcase
            if (o != 6'b000000) f = 6'($urandom_range(0, 63));
            run_instr(o, f, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                      ($urandom_range(0, 19) == 0) ? 0 : -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
